// File: rtl/lamp_pkg.sv
// Shared lamp codes, timer FSM states and default dwell times for the
// lamp step timer and the downstream lamp stage.
package lamp_pkg;

   localparam logic [0:2] RED    = 3'b100;
   localparam logic [0:2] YELLOW = 3'b010;
   localparam logic [0:2] GREEN  = 3'b001;

   typedef enum logic [1:0] {LOAD, COUNT, STEP, FAULT} state_t;

   localparam int RED_TICKS_DEF    = 20;
   localparam int YELLOW_TICKS_DEF = 4;
   localparam int GREEN_TICKS_DEF  = 16;

endpackage

// File: rtl/lamp_step_timer.sv
// Dwell timer that pulses step to advance the lamp stage once per phase.
// Pedestrian shortening of green is built only with LAMP_STEP_TIMER_PED_EN.
module lamp_step_timer
   import lamp_pkg::*;
#(
   parameter int RED_TICKS    = RED_TICKS_DEF,
   parameter int YELLOW_TICKS = YELLOW_TICKS_DEF,
   parameter int GREEN_TICKS  = GREEN_TICKS_DEF,
   parameter int WIDTH        = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [0:2]       light,
   input  logic             ped_req,
   output logic             ped_ack,
   output logic             step,
   output logic [WIDTH-1:0] remaining,
   output logic             fault
);

   localparam logic [WIDTH-1:0] PED_CAP = WIDTH'(2);

   state_t           state, next_state;
   logic [WIDTH-1:0] counter, counter_next;
   logic [WIDTH-1:0] dwell_m1;
   logic             one_hot;
   logic             accept;

   assign one_hot   = (light == RED) || (light == YELLOW) || (light == GREEN);
   assign remaining = counter;

   always_comb begin
      dwell_m1 = WIDTH'(GREEN_TICKS - 1);
      case (light)
         RED:     dwell_m1 = WIDTH'(RED_TICKS - 1);
         YELLOW:  dwell_m1 = WIDTH'(YELLOW_TICKS - 1);
         default: dwell_m1 = WIDTH'(GREEN_TICKS - 1);
      endcase
   end

`ifdef LAMP_STEP_TIMER_PED_EN
   logic ped_served;

   assign accept = (state == COUNT) && (light == GREEN) && ped_req && !ped_served;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ped_served <= 1'b0;
         ped_ack    <= 1'b0;
      end else begin
         ped_ack <= accept;
         if (state == LOAD)
            ped_served <= 1'b0;
         else if (accept)
            ped_served <= 1'b1;
      end
   end
`else
   logic unused_ped;

   assign unused_ped = ped_req;
   assign accept     = 1'b0;
   assign ped_ack    = 1'b0;
`endif

   always_comb begin
      next_state   = state;
      counter_next = counter;
      if (!one_hot) begin
         next_state = FAULT;
      end else begin
         case (state)
            LOAD: begin
               counter_next = dwell_m1;
               next_state   = COUNT;
            end
            COUNT: begin
               // An accepted request caps the count but never blocks the expiry.
               if (accept && (counter > PED_CAP))
                  counter_next = PED_CAP;
               if (enable) begin
                  if (counter == '0)
                     next_state = STEP;
                  else if (!accept)
                     counter_next = counter - WIDTH'(1);
               end
            end
            STEP:  next_state = LOAD;
            FAULT: next_state = LOAD;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= LOAD;
         counter <= '0;
         step    <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state   <= next_state;
         counter <= counter_next;
         step    <= (next_state == STEP);
         fault   <= (next_state == FAULT);
      end
   end

endmodule

// File: tb/tb_lamp_step_timer.sv
// Directed bench for lamp_step_timer driven by a behavioural lamp stage
// (red -> yellow -> green -> red) with an override for illegal codes.
module tb_lamp_step_timer;
   import lamp_pkg::*;

   localparam int WIDTH = 8;

   logic             clock;
   logic             reset_n;
   logic             enable;
   logic [0:2]       light;
   logic             ped_req;
   logic             ped_ack;
   logic             step;
   logic [WIDTH-1:0] remaining;
   logic             fault;

   logic [0:2]       lamp;
   logic [0:2]       ovr;
   logic             ovr_en;

   int errs   = 0;
   int checks = 0;

   lamp_step_timer #(
      .RED_TICKS   (20),
      .YELLOW_TICKS(4),
      .GREEN_TICKS (16),
      .WIDTH       (WIDTH)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (enable),
      .light    (light),
      .ped_req  (ped_req),
      .ped_ack  (ped_ack),
      .step     (step),
      .remaining(remaining),
      .fault    (fault)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) begin
      if (!reset_n)
         lamp <= RED;
      else if (step)
         lamp <= (lamp == RED) ? YELLOW : (lamp == YELLOW) ? GREEN : RED;
   end

   assign light = ovr_en ? ovr : lamp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // n = negedges until step is seen high, -1 if the budget runs out
   task automatic wait_step(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clock);
         if (step) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1);
   end

   initial begin
      int               n, k, acks, frz_bad, hit;
      int               iv[4];
      logic             en_b;
      logic [WIDTH-1:0] r_b, rem_at;
      logic [0:2]       lamp_at;

      reset_n = 1'b0; enable = 1'b0; ped_req = 1'b0; ovr_en = 1'b0; ovr = 3'b000;
      repeat (2) @(negedge clock);
      chk("rst_step",  step,      0);
      chk("rst_fault", fault,     0);
      chk("rst_ack",   ped_ack,   0);
      chk("rst_rem",   remaining, 0);

      // free-running phase sequence from red
      reset_n = 1'b1; enable = 1'b1;
      wait_step(100, n); chk("first_red", n, 21);
      wait_step(100, n); chk("yellow_iv", n, 6);
      wait_step(100, n); chk("green_iv",  n, 18);
      wait_step(100, n); chk("red_iv",    n, 22);
      @(negedge clock);  chk("step_pulse", step, 0);

      // reset landing on a STEP cycle
      wait_step(100, n);
      reset_n = 1'b0;
      @(negedge clock);
      chk("rst_in_step_step", step, 0);
      chk("rst_in_step_rem",  remaining, 0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_in_step_load", remaining, 19);

      // reset mid-COUNT at remaining 7
      hit = 0;
      for (int i = 0; i < 50; i++) begin
         if (remaining == 7) begin hit = 1; break; end
         @(negedge clock);
      end
      chk("reach_rem7", hit, 1);
      reset_n = 1'b0;
      @(negedge clock);
      chk("midcnt_rem",   remaining, 0);
      chk("midcnt_step",  step,      0);
      chk("midcnt_fault", fault,     0);
      chk("midcnt_ack",   ped_ack,   0);
      reset_n = 1'b1;

      // illegal lamp code mid-COUNT
      repeat (5) @(negedge clock);
      ovr_en = 1'b1; ovr = 3'b011;
      @(negedge clock);
      chk("fault_set",  fault, 1);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (step) k++;
      end
      chk("fault_nostep", k, 0);
      chk("fault_held",   fault, 1);
      ovr_en = 1'b0;
      @(negedge clock);
      chk("fault_clear", fault, 0);
      wait_step(100, n);
      chk("fault_recover", n + 1, 22);

      // enable toggling every cycle
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1; enable = 1'b1;
      k = 0; n = 0; frz_bad = 0;
      for (int i = 0; i < 400 && k < 4; i++) begin
         en_b = enable; r_b = remaining;
         @(negedge clock);
         n++;
         if (!en_b && r_b != 0 && remaining != r_b) frz_bad++;
         if (step) begin iv[k] = n; k++; n = 0; end
         enable = ~enable;
      end
      chk("tog_steps",  k,     4);
      chk("tog_red0",   iv[0], 41);
      chk("tog_yellow", iv[1], 10);
      chk("tog_green",  iv[2], 34);
      chk("tog_red",    iv[3], 42);
      chk("tog_frozen", frz_bad, 0);

      reset_n = 1'b0; enable = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
`ifdef LAMP_STEP_TIMER_PED_EN
      // request raised during red stays pending until green COUNT
      ped_req = 1'b1;
      acks = 0; k = 0; n = 0; lamp_at = 3'b000; rem_at = '0;
      for (int i = 0; i < 200 && k < 3; i++) begin
         @(negedge clock);
         n++;
         if (ped_ack) begin
            acks++;
            if (acks == 1) begin lamp_at = lamp; rem_at = remaining; ped_req = 1'b0; end
         end
         if (step) k++;
      end
      chk("hold_acks",   acks,    1);
      chk("hold_light",  lamp_at, 3'b001);
      chk("hold_rem",    rem_at,  2);
      chk("hold_green_end", n, 33);

      // green at remaining 10: shortened to 2, second request refused
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (lamp == GREEN && remaining == 10) begin hit = 1; break; end
      end
      chk("reach_g10", hit, 1);
      ped_req = 1'b1;
      @(negedge clock);
      chk("ped_ack", ped_ack,   1);
      chk("ped_rem", remaining, 2);
      ped_req = 1'b0;
      @(negedge clock);
      chk("ack_pulse", ped_ack,   0);
      chk("ped_rem1",  remaining, 1);
      ped_req = 1'b1;
      @(negedge clock);
      chk("second_req", ped_ack, 0);
      @(negedge clock);
      chk("ped_step",  step,    1);
      chk("ped_noack", ped_ack, 0);
      ped_req = 1'b0;
`else
      // pedestrian input has no effect in this build
      ped_req = 1'b1;
      wait_step(100, n);
      chk("noped_first", n, 21);
      acks = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (ped_ack) acks++;
      end
      chk("noped_acks", acks, 0);
      ped_req = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
